// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined WIDTH-bit rotate/shift unit.
// Stage k applies a 2^k shift; valid/ready on both ends with a global stall.
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam logic [1:0] M_ROL = 2'b00;
  localparam logic [1:0] M_ROR = 2'b01;
  localparam logic [1:0] M_SHL = 2'b10;

  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input int unsigned      s
  );
    logic [WIDTH-1:0] v;
    unique case (m)
      M_ROL:   v = (d << s) | (d >> (WIDTH - s));
      M_ROR:   v = (d >> s) | (d << (WIDTH - s));
      M_SHL:   v = d << s;
      default: v = WIDTH'($signed(d) >>> s);
    endcase
    return v;
  endfunction

  logic             r_valid [SHW];
  logic [WIDTH-1:0] r_data  [SHW];
  logic [SHW-1:0]   r_amt   [SHW];
  logic [1:0]       r_mode  [SHW];
  logic             r_carry [SHW];

  logic             w_v  [SHW];
  logic [WIDTH-1:0] w_d  [SHW];
  logic [SHW-1:0]   w_a  [SHW];
  logic [1:0]       w_m  [SHW];
  logic             w_c  [SHW];
  logic [WIDTH-1:0] w_nd [SHW];

  logic             w_stall;
  logic             w_cin;
  logic [SHW-1:0]   w_lidx;
  logic [SHW-1:0]   w_ridx;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Carry is the last bit leaving the word; both rotate and shift
  // variants of a direction pick the same source bit of in_data.
  assign w_lidx = '0 - in_amt;
  assign w_ridx = in_amt - SHW'(1);

  always_comb begin
    w_cin = 1'b0;
    if (in_amt != '0)
      w_cin = in_mode[0] ? in_data[w_ridx] : in_data[w_lidx];
  end

  assign w_v[0] = in_valid;
  assign w_d[0] = in_data;
  assign w_a[0] = in_amt;
  assign w_m[0] = in_mode;
  assign w_c[0] = w_cin;

  for (genvar k = 1; k < SHW; k++) begin : g_link
    assign w_v[k] = r_valid[k-1];
    assign w_d[k] = r_data[k-1];
    assign w_a[k] = r_amt[k-1];
    assign w_m[k] = r_mode[k-1];
    assign w_c[k] = r_carry[k-1];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_shift
    assign w_nd[k] = w_a[k][k] ? f_shift(w_d[k], w_m[k], 2**k) : w_d[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_amt[k]   <= '0;
        r_mode[k]  <= 2'b00;
        r_carry[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < SHW; k++) begin
        r_valid[k] <= w_v[k];
        r_data[k]  <= w_nd[k];
        r_amt[k]   <= w_a[k];
        r_mode[k]  <= w_m[k];
        r_carry[k] <= w_c[k];
      end
    end
  end

  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_carry = r_carry[SHW-1];
  assign out_zero  = ~|out_data;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: scoreboard bench for WIDTH 8/16/32 instances.
// Expected results come from a bit-index reference model.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: result bit i is taken from a source bit chosen by mode.
  function automatic logic [64:0] ref_op(input logic [63:0] d, input int amt,
                                         input logic [1:0] m, input int w);
    logic [63:0] r;
    logic c;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = d[6'((i - amt + w) % w)];
        2'b01:   r[i] = d[6'((i + amt) % w)];
        2'b10:   r[i] = (i >= amt) ? d[6'(i - amt)] : 1'b0;
        default: r[i] = (i + amt < w) ? d[6'(i + amt)] : d[6'(w - 1)];
      endcase
    end
    if (amt == 0) c = 1'b0;
    else begin
      case (m)
        2'b00:   c = r[0];
        2'b01:   c = r[6'(w - 1)];
        2'b10:   c = d[6'(w - amt)];
        default: c = d[6'(amt - 1)];
      endcase
    end
    return {c, r};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = 8 << gi;
    localparam int S = $clog2(W);

    typedef struct {
      logic [W-1:0] d;
      logic         c;
      int           ca;
      int           sa;
    } exp_t;

    logic         rst  = 1'b1;
    logic         iv   = 1'b0;
    logic         ordy = 1'b1;
    logic [W-1:0] id   = '0;
    logic [S-1:0] ia   = '0;
    logic [1:0]   im   = 2'b00;
    logic         ir, ov, oc, oz;
    logic [W-1:0] od;
    logic [64:0]  r_e;
    exp_t         q[$];
    int           cyc = 0;
    int           stl = 0;
    bit           fin = 1'b0;

    barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir),
      .in_data(id), .in_amt(ia), .in_mode(im),
      .out_valid(ov), .out_ready(ordy),
      .out_data(od), .out_carry(oc), .out_zero(oz)
    );

    function automatic string nm(input string s);
      return $sformatf("w%0d %s", W, s);
    endfunction

    always @(posedge clk) begin
      cyc++;
      if (rst) q.delete();
      else begin
        if (ov && !ordy) stl++;
        if (iv && ir) begin
          r_e = ref_op(64'(id), int'(ia), im, W);
          q.push_back('{d: r_e[W-1:0], c: r_e[64], ca: cyc, sa: stl});
        end
      end
    end

    always @(negedge clk) begin
      #2;
      if (!rst) begin
        check(nm("in_ready"), 64'(ir), 64'(!(ov && !ordy)));
        if (ov) begin
          check(nm("pending"), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            check(nm("data"), 64'(od), 64'(q[0].d));
            check(nm("carry"), 64'(oc), 64'(q[0].c));
            check(nm("zero"), 64'(oz), 64'(q[0].d == '0));
            check(nm("latency"), 64'((cyc - q[0].ca) - (stl - q[0].sa)),
                  64'(S - 1));
            if (ordy) void'(q.pop_front());
          end
        end
      end
    end

    task automatic send(input logic [W-1:0] d, input int a,
                        input logic [1:0] m);
      int n = 0;
      iv = 1'b1; id = d; ia = S'(a); im = m;
      #1;
      while (!ir && n < 50) begin
        @(negedge clk); #1; n++;
      end
      check(nm("accept"), 64'(ir), 64'd1);
      @(negedge clk);
      iv = 1'b0;
    endtask

    task automatic send_rand();
      send(W'($urandom()), int'($urandom_range(0, W - 1)),
           2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
      iv = 1'b0; ordy = 1'b1;
      for (int i = 0; i < 64 && q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check(nm("drained"), 64'(q.size()), 64'd0);
      check(nm("idle valid"), 64'(ov), 64'd0);
    endtask

    initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check(nm("rst valid"), 64'(ov), 64'd0);
      check(nm("rst data"), 64'(od), 64'd0);
      check(nm("rst carry"), 64'(oc), 64'd0);
      check(nm("rst zero"), 64'(oz), 64'd1);
      rst = 1'b0;
      #1 check(nm("rst in_ready"), 64'(ir), 64'd1);
      @(negedge clk);

      send(W'(8'h96), 3, 2'b00);
      send(W'(8'h81), 1, 2'b01);
      send(W'(8'h81), 1, 2'b10);
      send(W'(8'h80), 1, 2'b10);
      send(W'(8'h90), 4, 2'b11);
      send(W'(8'h80), 7, 2'b11);
      for (int m = 0; m < 4; m++) send(W'(8'hA5), 0, 2'(m));
      for (int i = 0; i < 16; i++) send_rand();
      drain();

      // Fill the pipe, then hold the consumer off for five cycles.
      for (int i = 0; i < 12 && !ov; i++) send_rand();
      check(nm("fill"), 64'(ov), 64'd1);
      ordy = 1'b0;
      iv = 1'b1; id = W'($urandom()); ia = S'($urandom_range(0, W - 1));
      im = 2'($urandom_range(0, 3));
      repeat (5) begin
        @(negedge clk); #1;
        check(nm("stall in_ready"), 64'(ir), 64'd0);
      end
      ordy = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      drain();

      send_rand(); send_rand(); send_rand();
      rst = 1'b1;
      @(negedge clk);
      check(nm("mid rst valid"), 64'(ov), 64'd0);
      rst = 1'b0;
      send_rand();
      drain();

      for (int i = 0; i < 60; i++) begin
        ordy = ($urandom_range(0, 3) != 0);
        iv   = ($urandom_range(0, 4) != 0);
        id   = W'($urandom());
        ia   = S'($urandom_range(0, W - 1));
        im   = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (g_w[0].fin && g_w[1].fin && g_w[2].fin) break;
    end
    if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: actual unfinished required finished");
    end
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
